mem_req_unit: RTL and testbench

Memory-stage request controller that sits downstream of the EX/MEM pipeline latch. It consumes that latch's read, write and atomic controls plus its address and store data, and drives the single-outstanding-request handshake to the data cache. It produces the memory-stage stall that holds the upstream latches, and implements the LL/SC link register, including coherence-snoop invalidation.

---
 rtl/mem_req_unit.sv | 96 +++++++++
 tb/tb_mem_req_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_unit.sv
// mem_req_unit: memory-stage cache request controller with stall and LL/SC link register
module mem_req_unit #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pipe_en,
  input  logic              mem_dre,
  input  logic              mem_dwe,
  input  logic              mem_datomic,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  input  logic              ccinv,
  input  logic [DATA_W-1:0] ccsnoopaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              link_valid
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t            r_state, w_next;
  logic              r_link_valid, r_sc_q;
  logic [DATA_W-1:0] r_link_addr, r_rdata_q;
  logic              w_req, w_sc, w_ll, w_snoop_hit, w_sc_ok, w_sc_fail, w_done;
  assign w_req       = mem_dre | mem_dwe;
  assign w_sc        = mem_dwe & mem_datomic;
  assign w_ll        = mem_dre & ~mem_dwe & mem_datomic;
  assign w_snoop_hit = ccinv & (ccsnoopaddr == r_link_addr);
  assign w_sc_ok     = r_link_valid & (r_link_addr == mem_addr) & ~w_snoop_hit;
  assign dmemaddr    = mem_addr;
  assign dmemstore   = mem_wdata;
  assign link_valid  = r_link_valid;
  // next state and handshake outputs; everything is forced to reset values while nRST is low
  always_comb begin
    w_next    = r_state;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    mem_stall = 1'b0;
    mem_rdata = '0;
    w_sc_fail = 1'b0;
    w_done    = 1'b0;
    if (nRST) begin
      case (r_state)
        IDLE: if (w_req) begin
          if (w_sc & ~w_sc_ok) begin
            w_sc_fail = 1'b1;
            w_next    = pipe_en ? IDLE : DONE;
          end else begin
            mem_stall = 1'b1;
            w_next    = REQ;
          end
        end
        REQ: begin
          dmemREN   = mem_dre & ~mem_dwe;
          dmemWEN   = mem_dwe;
          mem_stall = ~dhit;
          if (dhit) begin
            w_done    = 1'b1;
            mem_rdata = w_sc ? {{(DATA_W-1){1'b0}}, 1'b1} : dmemload;
            w_next    = pipe_en ? IDLE : DONE;
          end
        end
        DONE: begin
          mem_rdata = w_sc ? {{(DATA_W-1){1'b0}}, r_sc_q} : r_rdata_q;
          if (pipe_en) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end
  // state, captured results and link register; an LL completing outranks a same-cycle snoop
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
      r_rdata_q    <= '0;
      r_sc_q       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_done & mem_dre & ~mem_dwe) r_rdata_q <= dmemload;
      if (w_done & w_sc) r_sc_q <= 1'b1;
      else if (w_sc_fail) r_sc_q <= 1'b0;
      if (w_done & w_ll) begin
        r_link_valid <= 1'b1;
        r_link_addr  <= mem_addr;
      end else if (w_sc_fail | w_snoop_hit | (w_done & mem_dwe & (w_sc | (mem_addr == r_link_addr))))
        r_link_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_req_unit.sv
// tb_mem_req_unit: randomized and directed checks of mem_req_unit against a transaction-level model
module tb_mem_req_unit;
  logic        CLK = 0, nRST = 0;
  logic        pipe_en = 0, mem_dre = 0, mem_dwe = 0, mem_datomic = 0, dhit = 0, ccinv = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, dmemload = 0, ccsnoopaddr = 0;
  logic        dmemREN, dmemWEN, mem_stall, link_valid;
  logic [31:0] dmemaddr, dmemstore, mem_rdata;
  int          tests = 0, fails = 0;
  bit          m_valid = 0;
  logic [31:0] m_addr = 0;

  localparam int LOAD = 0, STORE = 1, LL = 2, SC = 3;

  mem_req_unit #(.DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .mem_dre(mem_dre), .mem_dwe(mem_dwe),
    .mem_datomic(mem_datomic), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dhit(dhit),
    .dmemload(dmemload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
    .mem_rdata(mem_rdata), .link_valid(link_valid)
  );

  always #5 CLK = ~CLK;

  task automatic go_idle();
    @(posedge CLK); #1;
    mem_dre = 0; mem_dwe = 0; mem_datomic = 0; pipe_en = 0; dhit = 0; ccinv = 0;
    @(negedge CLK);
    tests++;
    if (link_valid !== m_valid || mem_stall !== 0 || mem_rdata !== 0 || dmemREN !== 0 || dmemWEN !== 0) begin
      fails++;
      $display("FAIL idle_link: link_valid=%b stall=%b rdata=%h ren=%b wen=%b, required link_valid=%b stall=0 rdata=0 ren=0 wen=0",
               link_valid, mem_stall, mem_rdata, dmemREN, dmemWEN, m_valid);
    end
  endtask

  // one memory instruction: snoop_cyc -1 none, 0 in the IDLE cycle, k in REQ cycle k
  task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wd, input int lat,
                       input int snoop_cyc, input logic [31:0] saddr, input bit adv_now, input logic [31:0] ldata);
    bit          wr = (kind == STORE) || (kind == SC);
    bit          sc_ok;
    logic [31:0] exp_r;
    @(posedge CLK); #1;
    mem_dre = !wr; mem_dwe = wr; mem_datomic = (kind >= LL); mem_addr = addr; mem_wdata = wd;
    pipe_en = 0; dhit = 0; dmemload = $urandom; ccinv = (snoop_cyc == 0); ccsnoopaddr = saddr;
    sc_ok = m_valid && (m_addr == addr) && !(snoop_cyc == 0 && saddr == m_addr);
    if (snoop_cyc == 0 && saddr == m_addr) m_valid = 0;
    @(negedge CLK);
    if (kind == SC && !sc_ok) begin
      tests++;
      if (mem_stall !== 0 || dmemREN !== 0 || dmemWEN !== 0 || mem_rdata !== 0) begin
        fails++;
        $display("FAIL scfail_idle: stall=%b ren=%b wen=%b rdata=%h, required 0 0 0 0", mem_stall, dmemREN, dmemWEN, mem_rdata);
      end
      m_valid = 0;
      for (int k = 0; k < 2; k++) begin
        @(posedge CLK); #1;
        ccinv = 0; pipe_en = (k == 1);
        @(negedge CLK);
        tests++;
        if (mem_stall !== 0 || dmemWEN !== 0 || dmemREN !== 0 || mem_rdata !== 0) begin
          fails++;
          $display("FAIL scfail_done: stall=%b ren=%b wen=%b rdata=%h, required 0 0 0 0", mem_stall, dmemREN, dmemWEN, mem_rdata);
        end
      end
    end else begin
      tests++;
      if (mem_stall !== 1 || dmemREN !== 0 || dmemWEN !== 0) begin
        fails++;
        $display("FAIL idle_stall: stall=%b ren=%b wen=%b, required 1 0 0", mem_stall, dmemREN, dmemWEN);
      end
      exp_r = (kind == SC) ? 32'd1 : ldata;
      for (int k = 1; k <= lat; k++) begin
        @(posedge CLK); #1;
        ccinv = (snoop_cyc == k); dhit = (k == lat); dmemload = (k == lat) ? ldata : $urandom;
        pipe_en = (k == lat) && adv_now;
        if (ccinv && saddr == m_addr) m_valid = 0;
        @(negedge CLK);
        tests++;
        if (dmemREN !== !wr || dmemWEN !== wr || dmemaddr !== addr || dmemstore !== wd || mem_stall !== (k != lat)) begin
          fails++;
          $display("FAIL req_cycle%0d: ren=%b wen=%b addr=%h store=%h stall=%b, required %b %b %h %h %b",
                   k, dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, !wr, wr, addr, wd, k != lat);
        end
        if (k == lat && kind != STORE) begin
          tests++;
          if (mem_rdata !== exp_r) begin
            fails++;
            $display("FAIL hit_rdata: got %h, required %h", mem_rdata, exp_r);
          end
        end
      end
      if (kind == LL) begin m_valid = 1; m_addr = addr; end
      else if (kind == SC || (kind == STORE && addr == m_addr)) m_valid = 0;
      if (!adv_now) begin
        for (int k = 0; k < 2; k++) begin
          @(posedge CLK); #1;
          dhit = 0; ccinv = 0; dmemload = $urandom; pipe_en = (k == 1);
          @(negedge CLK);
          tests++;
          if (mem_stall !== 0 || dmemREN !== 0 || dmemWEN !== 0 || (kind != STORE && mem_rdata !== exp_r)) begin
            fails++;
            $display("FAIL done_hold: stall=%b ren=%b wen=%b rdata=%h, required 0 0 0 %h", mem_stall, dmemREN, dmemWEN, mem_rdata, exp_r);
          end
        end
      end
    end
    go_idle();
  endtask

  task automatic snoop(input logic [31:0] saddr);
    @(posedge CLK); #1;
    ccinv = 1; ccsnoopaddr = saddr;
    if (saddr == m_addr) m_valid = 0;
    go_idle();
  endtask

  task automatic test_reset();
    nRST = 0; mem_dre = 1; mem_addr = 32'h1234; mem_wdata = 32'h5678;
    #12;
    tests++;
    if (mem_stall !== 0 || dmemREN !== 0 || dmemWEN !== 0 || mem_rdata !== 0 || link_valid !== 0 ||
        dmemaddr !== 32'h1234 || dmemstore !== 32'h5678) begin
      fails++;
      $display("FAIL reset: stall=%b ren=%b wen=%b rdata=%h link=%b addr=%h store=%h, required 0 0 0 0 0 1234 5678",
               mem_stall, dmemREN, dmemWEN, mem_rdata, link_valid, dmemaddr, dmemstore);
    end
    mem_dre = 0;
    @(negedge CLK); nRST = 1;
    m_valid = 0; m_addr = 0;
    go_idle();
  endtask

  task automatic test_load();
    do_op(LOAD, 32'h40, 0, 2, -1, 0, 0, 32'hDEADBEEF);
    do_op(LOAD, 32'h44, 0, 1, -1, 0, 1, 32'h0BADF00D);
  endtask

  task automatic test_llsc();
    do_op(LL, 32'h100, 0, 1, -1, 0, 1, 32'h11);
    do_op(SC, 32'h100, 5, 1, -1, 0, 0, 0);
    do_op(LL, 32'h100, 0, 1, -1, 0, 1, 32'h22);
    snoop(32'h100);
    do_op(SC, 32'h100, 5, 1, -1, 0, 0, 0);
  endtask

  task automatic test_snoop_timing();
    do_op(LL, 32'h100, 0, 1, -1, 0, 1, 32'h33);
    do_op(SC, 32'h100, 7, 1, 0, 32'h100, 0, 0);
    do_op(LL, 32'h100, 0, 1, -1, 0, 1, 32'h44);
    do_op(SC, 32'h100, 7, 1, 0, 32'h104, 1, 0);
    do_op(LL, 32'h100, 0, 1, -1, 0, 1, 32'h55);
    do_op(SC, 32'h100, 9, 3, 2, 32'h100, 0, 0);
    do_op(LL, 32'h100, 0, 2, 2, 32'h100, 0, 32'h66);
  endtask

  task automatic test_store_breaks_link();
    do_op(LL, 32'h100, 0, 1, -1, 0, 1, 32'h77);
    do_op(STORE, 32'h100, 3, 1, -1, 0, 1, 0);
    do_op(SC, 32'h100, 4, 1, -1, 0, 0, 0);
    do_op(LL, 32'h100, 0, 1, -1, 0, 1, 32'h88);
    do_op(STORE, 32'h200, 3, 2, -1, 0, 0, 0);
    do_op(SC, 32'h100, 4, 1, -1, 0, 1, 0);
  endtask

  task automatic test_reset_mid_req();
    do_op(LL, 32'h100, 0, 1, -1, 0, 1, 32'h99);
    @(posedge CLK); #1;
    mem_dre = 1; mem_datomic = 0; mem_addr = 32'h300;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 0;
    #1;
    tests++;
    if (dmemREN !== 0 || dmemWEN !== 0 || mem_stall !== 0 || mem_rdata !== 0 || link_valid !== 0) begin
      fails++;
      $display("FAIL reset_mid_req: ren=%b wen=%b stall=%b rdata=%h link=%b, required all 0",
               dmemREN, dmemWEN, mem_stall, mem_rdata, link_valid);
    end
    mem_dre = 0; m_valid = 0; m_addr = 0;
    @(negedge CLK); nRST = 1;
    do_op(LOAD, 32'h300, 0, 2, -1, 0, 0, 32'hCAFE0001);
    do_op(SC, 32'h0, 1, 1, -1, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] addrs [3] = '{32'h100, 32'h104, 32'h200};
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(3);
      int lat  = $urandom_range(1, 4);
      int sc   = ($urandom_range(2) == 0) ? $urandom_range(lat) : -1;
      do_op(kind, addrs[$urandom_range(2)], $urandom, lat, sc, addrs[$urandom_range(2)], $urandom_range(1), $urandom);
      if ($urandom_range(4) == 0) snoop(addrs[$urandom_range(2)]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_llsc();
    test_snoop_timing();
    test_store_breaks_link();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
